// File: rtl/bin_to_bcd_pkg.sv
// Shared widths, iteration count and types for the 8-bit binary to 3-digit BCD converter.
package bin_to_bcd_pkg;
  localparam int BIN_W      = 8;
  localparam int BCD_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int ITER_CNT   = 8;
  localparam int CNT_W      = 4;
  localparam int SR_W       = BIN_W + BCD_DIGITS * DIGIT_W;

  typedef enum logic {IDLE, SHIFT} state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] h;
    logic [DIGIT_W-1:0] t;
    logic [DIGIT_W-1:0] o;
  } bcd_t;
endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 so the next shift carries into the next decade.
module bcd_digit_adjust
  import bin_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  assign dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 converter: one adjust+shift per clock, result registered after ITER_CNT shifts.
module bin_to_bcd_converter
  import bin_to_bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic [DIGIT_W-1:0] H,
  output logic [DIGIT_W-1:0] T,
  output logic [DIGIT_W-1:0] O,
  output logic               busy,
  output logic               valid
);
  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [SR_W-1:0]                   sr_q, sr_d, sr_adj, sr_shift;
  bcd_t                              res_q, res_d;
  logic                              valid_q, valid_d;
  logic [BCD_DIGITS-1:0][DIGIT_W-1:0] nib_adj;

  // Digit g (0 = ones) sits just above the binary field of the working register.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (sr_q[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .dout (nib_adj[g])
    );
  end

  assign sr_adj   = {nib_adj, sr_q[BIN_W-1:0]};
  assign sr_shift = {sr_adj[SR_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    res_d   = res_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{(SR_W-BIN_W){1'b0}}, bin};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // Last shift: capture digits straight from the shifted value, start is not looked at here.
        if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
          res_d   = sr_shift[SR_W-1:BIN_W];
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign H     = res_q.h;
  assign T     = res_q.t;
  assign O     = res_q.o;
  assign busy  = (state_q == SHIFT);
  assign valid = valid_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed and random checks of the BCD converter against an arithmetic divide/modulo reference.
module tb_bin_to_bcd_converter;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] bin;
  logic [3:0] H, T, O;
  logic       busy, valid;

  int errors = 0;
  int checks = 0;
  logic [11:0] held;

  bin_to_bcd_converter dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .H(H), .T(T), .O(O), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic chk_out(input string tag, input logic [11:0] d, input logic b, input logic v);
    chk({tag, "_digits"}, {H, T, O}, d);
    chk({tag, "_busy"}, {11'd0, busy}, {11'd0, b});
    chk({tag, "_valid"}, {11'd0, valid}, {11'd0, v});
  endtask

  // Start a conversion of v; poke[k] drives start=1,bin=0 into edge t0+k (k=1..8).
  task automatic convert(input logic [7:0] v, input logic [8:0] poke, input bit idle_chk);
    logic [11:0] expd;
    expd  = ref_bcd(int'(v));
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk_out("busy_hold", held, 1'b1, 1'b0);
      start = poke[k+1];
      bin   = poke[k+1] ? 8'd0 : 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk_out($sformatf("done_%0d", v), expd, 1'b0, 1'b1);
    held = expd;
    if (idle_chk) begin
      @(negedge clk);
      chk_out("after_done", held, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int sweep [19];
    sweep = '{0, 2, 3, 5, 8, 10, 32, 48, 80, 128, 160, 17, 34, 51, 85, 136, 170, 204, 255};
    held  = '0;
    rst   = 1'b1;
    start = 1'b1;
    bin   = 8'd255;
    @(negedge clk);
    chk_out("reset1", 12'h000, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk_out("reset2", 12'h000, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_out("idle", 12'h000, 1'b0, 1'b0);

    foreach (sweep[i]) convert(8'(sweep[i]), 9'd0, 1'b1);

    // Requests during the run and on the completion edge are both dropped.
    convert(8'd99, 9'd0, 1'b1);
    convert(8'd255, 9'b1_0000_1000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk_out("ignored_start", 12'h255, 1'b0, 1'b0);
    end

    // Reset lands on edge t0+4 of a running conversion.
    start = 1'b1;
    bin   = 8'd204;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    chk_out("rst_mid", 12'h000, 1'b0, 1'b0);
    held = '0;
    repeat (9) begin
      @(negedge clk);
      chk_out("post_rst", 12'h000, 1'b0, 1'b0);
    end
    convert(8'd170, 9'd0, 1'b1);

    // Back-to-back: second start at t0+9.
    convert(8'd99, 9'd0, 1'b0);
    convert(8'd200, 9'd0, 1'b1);

    repeat (20) convert(8'($urandom_range(0, 255)), 9'd0, ($urandom_range(0, 1) == 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
